// File: rtl/banco_registradores_pkg.sv
// Shared constants for the MIPS register file, control unit and write-register select mux.
// Register index width is fixed at 5 bits by the ISA.
package banco_registradores_pkg;

  localparam int NREG_DEF  = 32;
  localparam int WIDTH_DEF = 32;
  localparam int IDX_W     = 5;

  localparam logic [IDX_W-1:0] REG_ZERO = 5'd0;
  localparam logic [IDX_W-1:0] REG_V0   = 5'd2;
  localparam logic [IDX_W-1:0] REG_SP   = 5'd29;
  localparam logic [IDX_W-1:0] REG_RA   = 5'd31;

  typedef enum logic {
    REG_WRITE_OFF = 1'b0,
    REG_WRITE_ON  = 1'b1
  } reg_write_t;

  typedef enum logic {
    REG_DST_RT = 1'b0,
    REG_DST_RD = 1'b1
  } reg_dst_t;

  // A pending write lands on this read address; writes to $zero never hit.
  function automatic logic wr_hit(input logic en, input logic [IDX_W-1:0] waddr,
                                  input logic [IDX_W-1:0] raddr);
    return en && (waddr != REG_ZERO) && (waddr == raddr);
  endfunction

endpackage

// File: rtl/banco_registradores_porta_leitura.sv
// One combinational read port over the register array, with optional same-cycle write forwarding.
module porta_leitura
  import banco_registradores_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int WIDTH  = WIDTH_DEF,
  parameter int BYPASS = 1
) (
  input  logic [WIDTH-1:0] regs [NREG],
  input  logic [IDX_W-1:0] addr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] data
);

  logic hit;

  assign hit = (BYPASS != 0) && wr_hit(wr_en, wr_addr, addr);

  always_comb begin
    data = '0;
    if (addr == REG_ZERO) begin
      data = '0;
    end else if (hit) begin
      data = wr_data;
    end else begin
      data = regs[addr];
    end
  end

endmodule

// File: rtl/banco_registradores.sv
// MIPS register file: one write port, two forwarded read ports (rs, rt), one raw debug port,
// and a wrapping count of committed writes. Async active-high clear of the whole flop array.
module banco_registradores
  import banco_registradores_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int WIDTH  = WIDTH_DEF,
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] regLeit1,
  input  logic [IDX_W-1:0] regLeit2,
  input  logic [IDX_W-1:0] regEsc,
  input  logic             escReg,
  input  logic [WIDTH-1:0] dadoEsc,
  output logic [WIDTH-1:0] dado1,
  output logic [WIDTH-1:0] dado2,
  input  logic [IDX_W-1:0] regDbg,
  output logic [WIDTH-1:0] dadoDbg,
  output logic [15:0]      nEscritas
);

  logic [WIDTH-1:0] regs [NREG];
  logic             wr_commit;

  // An X/Z index makes the compare unknown, so the write is dropped rather than smeared.
  assign wr_commit = escReg && (regEsc != REG_ZERO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      nEscritas <= '0;
    end else if (wr_commit) begin
      regs[regEsc] <= dadoEsc;
      nEscritas    <= nEscritas + 16'd1;
    end
  end

  porta_leitura #(.NREG(NREG), .WIDTH(WIDTH), .BYPASS(BYPASS)) u_porta1 (
    .regs    (regs),
    .addr    (regLeit1),
    .wr_en   (escReg),
    .wr_addr (regEsc),
    .wr_data (dadoEsc),
    .data    (dado1)
  );

  porta_leitura #(.NREG(NREG), .WIDTH(WIDTH), .BYPASS(BYPASS)) u_porta2 (
    .regs    (regs),
    .addr    (regLeit2),
    .wr_en   (escReg),
    .wr_addr (regEsc),
    .wr_data (dadoEsc),
    .data    (dado2)
  );

  // Debug port always shows committed state.
  porta_leitura #(.NREG(NREG), .WIDTH(WIDTH), .BYPASS(0)) u_porta_dbg (
    .regs    (regs),
    .addr    (regDbg),
    .wr_en   (1'b0),
    .wr_addr (REG_ZERO),
    .wr_data ('0),
    .data    (dadoDbg)
  );

endmodule

// File: tb/tb_banco_registradores.sv
// Self-checking bench for banco_registradores: forwarding and non-forwarding instances share stimulus;
// committed writes are queued with their expected data and popped at readback.
module tb_banco_registradores;

  logic        clk;
  logic        rst;
  logic [4:0]  regLeit1, regLeit2, regEsc, regDbg;
  logic        escReg;
  logic [31:0] dadoEsc;
  logic [31:0] dado1, dado2, dadoDbg;
  logic [15:0] nEscritas;
  logic [31:0] nb_dado1, nb_dado2, nb_dadoDbg;
  logic [15:0] nb_nEscritas;

  banco_registradores #(.NREG(32), .WIDTH(32), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .regLeit1(regLeit1), .regLeit2(regLeit2), .regEsc(regEsc),
    .escReg(escReg), .dadoEsc(dadoEsc), .dado1(dado1), .dado2(dado2), .regDbg(regDbg),
    .dadoDbg(dadoDbg), .nEscritas(nEscritas)
  );

  banco_registradores #(.NREG(32), .WIDTH(32), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .regLeit1(regLeit1), .regLeit2(regLeit2), .regEsc(regEsc),
    .escReg(escReg), .dadoEsc(dadoEsc), .dado1(nb_dado1), .dado2(nb_dado2), .regDbg(regDbg),
    .dadoDbg(nb_dadoDbg), .nEscritas(nb_nEscritas)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [32];
  logic [15:0] model_cnt;
  int          checks;
  int          errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one write, steps past the edge, and mirrors the effect into the model.
  task automatic do_write(input logic [4:0] r, input logic [31:0] d);
    escReg  = 1'b1;
    regEsc  = r;
    dadoEsc = d;
    @(posedge clk);
    #1;
    escReg = 1'b0;
    if (r != 5'd0) begin
      model[r]  = d;
      model_cnt = model_cnt + 16'd1;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    model_cnt = 16'd0;
  endtask

  task automatic drain_scoreboard();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      regLeit1 = e.addr;
      regLeit2 = e.addr;
      regDbg   = e.addr;
      #1;
      check($sformatf("rd1_r%0d", e.addr), dado1, e.data);
      check($sformatf("rd2_r%0d", e.addr), dado2, e.data);
      check($sformatf("dbg_r%0d", e.addr), dadoDbg, e.data);
      check($sformatf("nb_dbg_r%0d", e.addr), nb_dadoDbg, e.data);
    end
  endtask

  function automatic logic [31:0] pattern(input int r);
    logic [31:0] p;
    p = 32'h9E3779B9 * r;
    if (r == 8) p = 32'hDEADBEEF;
    return p;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    clear_model();
    rst = 1'b1;
    escReg = 1'b0;
    regEsc = 5'd0;
    dadoEsc = 32'd0;
    regLeit1 = 5'd3;
    regLeit2 = 5'd31;
    regDbg = 5'd8;
    #2;
    check("reset_rd1", dado1, 32'd0);
    check("reset_rd2", dado2, 32'd0);
    check("reset_dbg", dadoDbg, 32'd0);
    check("reset_cnt", {16'd0, nEscritas}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Every writable register once; the first write alone must bump the counter to 1.
    for (int r = 1; r < 32; r++) begin
      do_write(r[4:0], pattern(r));
      sb_q.push_back('{addr: r[4:0], data: pattern(r)});
      if (r == 1) check("cnt_first", {16'd0, nEscritas}, {16'd0, model_cnt});
    end
    drain_scoreboard();
    check("cnt_31", {16'd0, nEscritas}, {16'd0, model_cnt});
    check("nb_cnt_31", {16'd0, nb_nEscritas}, {16'd0, model_cnt});

    // Writes to $zero are discarded and never forwarded.
    escReg = 1'b1;
    regEsc = 5'd0;
    dadoEsc = 32'hFFFFFFFF;
    regLeit1 = 5'd0;
    regLeit2 = 5'd0;
    #1;
    check("zero_bypass", dado1, 32'd0);
    do_write(5'd0, 32'hFFFFFFFF);
    check("zero_rd1", dado1, 32'd0);
    check("zero_rd2", dado2, 32'd0);
    check("zero_cnt", {16'd0, nEscritas}, {16'd0, model_cnt});

    // Same-cycle write forwarding on both ports, debug stays on stored value.
    do_write(5'd5, 32'h11);
    escReg = 1'b1;
    regEsc = 5'd5;
    dadoEsc = 32'h22;
    regLeit1 = 5'd5;
    regLeit2 = 5'd5;
    regDbg = 5'd5;
    #1;
    check("byp_rd1", dado1, 32'h22);
    check("byp_rd2", dado2, 32'h22);
    check("byp_dbg_pre", dadoDbg, 32'h11);
    check("nobyp_rd1_pre", nb_dado1, 32'h11);
    @(posedge clk);
    #1;
    escReg = 1'b0;
    model[5] = 32'h22;
    model_cnt = model_cnt + 16'd1;
    #1;
    check("byp_dbg_post", dadoDbg, 32'h22);
    check("nobyp_rd1_post", nb_dado1, 32'h22);

    // Ports forward independently: only port 2 matches the write address.
    escReg = 1'b1;
    regEsc = 5'd6;
    dadoEsc = 32'hCAFE0006;
    regLeit1 = 5'd5;
    regLeit2 = 5'd6;
    #1;
    check("indep_rd1", dado1, model[5]);
    check("indep_rd2", dado2, 32'hCAFE0006);
    @(posedge clk);
    #1;
    escReg = 1'b0;
    model[6] = 32'hCAFE0006;
    model_cnt = model_cnt + 16'd1;

    // Write enable low: nothing commits.
    escReg = 1'b0;
    regEsc = 5'd9;
    dadoEsc = 32'h55;
    regLeit1 = 5'd9;
    #1;
    check("gate_rd1_pre", dado1, model[9]);
    @(posedge clk);
    #1;
    regDbg = 5'd9;
    #1;
    check("gate_dbg", dadoDbg, model[9]);
    check("gate_cnt", {16'd0, nEscritas}, {16'd0, model_cnt});

    // Asynchronous clear mid-cycle with every register loaded.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_cnt", {16'd0, nEscritas}, 32'd0);
    check("arst_nb_cnt", {16'd0, nb_nEscritas}, 32'd0);
    for (int r = 0; r < 32; r++) begin
      regLeit1 = r[4:0];
      regLeit2 = 5'(31 - r);
      regDbg = r[4:0];
      #1;
      check($sformatf("arst_rd1_r%0d", r), dado1, 32'd0);
      check($sformatf("arst_rd2_r%0d", 31 - r), dado2, 32'd0);
      check($sformatf("arst_dbg_r%0d", r), dadoDbg, 32'd0);
    end
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 65536 committed writes wrap the counter back to zero.
    escReg = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      regEsc = 5'((i % 31) + 1);
      dadoEsc = 32'(i) ^ 32'hA5A50000;
      @(posedge clk);
      #1;
      model[(i % 31) + 1] = 32'(i) ^ 32'hA5A50000;
      model_cnt = model_cnt + 16'd1;
    end
    escReg = 1'b0;
    check("wrap_cnt", {16'd0, nEscritas}, {16'd0, model_cnt});
    check("wrap_cnt_zero", {16'd0, nEscritas}, 32'd0);
    for (int r = 1; r < 32; r += 10) sb_q.push_back('{addr: r[4:0], data: model[r]});
    drain_scoreboard();

    // Reset held across an edge that carries a pending write: the write must not land.
    escReg = 1'b1;
    regEsc = 5'd7;
    dadoEsc = 32'h77;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #3;
    escReg = 1'b0;
    rst = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    check("rstw_cnt", {16'd0, nEscritas}, 32'd0);
    for (int r = 0; r < 32; r++) begin
      regDbg = r[4:0];
      #1;
      check($sformatf("rstw_dbg_r%0d", r), dadoDbg, model[r]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
